// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: loader FSM states and default RAM geometry.
package cpu_pkg;
  localparam int DEF_RAM_BYTES = 16;
  localparam int DEF_ADDR_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_RUN  = 2'd3
  } state_t;
endpackage

// File: rtl/prog_loader_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin, plus a registered rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic meta, sync, prev;

  // level is taken from the history flop so it lines up in time with rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

  assign level = prev;
endmodule

// File: rtl/prog_loader.sv
// Front-panel program loader: writes strobed bytes into program RAM, then releases the CPU.
// Optional feature: define PROG_LOADER_CHECKSUM_EN for a mod-256 checksum output.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int RAM_BYTES = DEF_RAM_BYTES,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              load_strobe,
  input  logic [7:0]        load_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_run,
  output logic              busy,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              overrun
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  state_t     state;
  logic [1:0] fill_cnt;
  logic       mode_lvl, strobe_evt;
  logic       mode_rise_unused, strobe_lvl_unused;

  sync_edge_detect u_mode_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (load_mode),
    .level    (mode_lvl),
    .rise     (mode_rise_unused)
  );

  sync_edge_detect u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (load_strobe),
    .level    (strobe_lvl_unused),
    .rise     (strobe_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fill_cnt <= 2'd0;
      ram_addr <= '0;
      ram_data <= 8'h00;
      ram_we   <= 1'b0;
      cpu_run  <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      checksum <= 8'h00;
`endif
    end else begin
      ram_we <= 1'b0;
      // address advances in the cycle after the write pulse, wrapping after the last byte
      if (ram_we) ram_addr <= ram_addr + 1'b1;

      case (state)
        ST_IDLE: begin
          // hold until the synchronisers carry real pin values rather than reset zeros
          if (fill_cnt != 2'd3) begin
            fill_cnt <= fill_cnt + 2'd1;
          end else if (mode_lvl) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            ram_addr <= '0;
            overrun  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            checksum <= 8'h00;
`endif
          end else begin
            state   <= ST_RUN;
            cpu_run <= 1'b1;
          end
        end

        ST_LOAD: begin
          // a pending byte wins over a mode drop; RUN follows on the next cycle
          if (strobe_evt) begin
            ram_we   <= 1'b1;
            ram_data <= load_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            checksum <= checksum + load_data;
`endif
            if (ram_addr == LAST_ADDR) begin
              state <= ST_FULL;
              busy  <= 1'b0;
            end
          end else if (!mode_lvl) begin
            state   <= ST_RUN;
            busy    <= 1'b0;
            cpu_run <= 1'b1;
          end
        end

        ST_FULL: begin
          if (strobe_evt) overrun <= 1'b1;
          if (!mode_lvl) begin
            state   <= ST_RUN;
            cpu_run <= 1'b1;
          end
        end

        ST_RUN: begin
          if (mode_lvl) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            cpu_run  <= 1'b0;
            ram_addr <= '0;
            overrun  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            checksum <= 8'h00;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader against a byte-count reference model.
module tb_prog_loader;
  localparam int RAM_BYTES = 16;
  localparam int ADDR_W    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_mode = 1'b0;
  logic              load_strobe = 1'b0;
  logic [7:0]        load_data = 8'h00;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              cpu_run;
  logic              busy;
  logic              overrun;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  prog_loader #(.RAM_BYTES(RAM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_mode   (load_mode),
    .load_strobe (load_strobe),
    .load_data   (load_data),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .ram_we      (ram_we),
    .cpu_run     (cpu_run),
    .busy        (busy),
`ifdef PROG_LOADER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: bytes accepted since load entry, sticky overrun, running sum
  bit          m_loading = 1'b0;
  int unsigned m_count = 0;
  bit          m_overrun = 1'b0;
  logic [7:0]  m_csum = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // write monitor: every RAM write must match the next expected byte
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'h0, ram_addr, ram_data[3:0]}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(ram_addr), 32'(e.addr));
        check("write_data", 32'(ram_data), 32'(e.data));
      end
    end
  end

  task automatic model_enter_load();
    m_loading = 1'b1;
    m_count   = 0;
    m_overrun = 1'b0;
    m_csum    = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit drop_mode);
    bit expect_write;
    expect_write = m_loading && (m_count < RAM_BYTES);
    if (expect_write) begin
      exp_q.push_back('{addr: m_count % RAM_BYTES, data: d});
      m_count++;
      m_csum = m_csum + d;
    end else if (m_loading) begin
      m_overrun = 1'b1;
    end
    if (drop_mode) m_loading = 1'b0;
    @(negedge clk);
    load_data   = d;
    load_strobe = 1'b1;
    if (drop_mode) load_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("we_early", 32'(ram_we), 32'd0);
    @(posedge clk);
    #1 check("we_latency", 32'(ram_we), 32'(expect_write));
    repeat (3) @(negedge clk);
    load_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (cpu_run !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("cpu_run_high", 32'(cpu_run), 32'd1);
    check("busy_in_run", 32'(busy), 32'd0);
  endtask

  task automatic set_mode(input bit v);
    @(negedge clk);
    load_mode = v;
    if (v) begin
      model_enter_load();
      repeat (6) @(negedge clk);
      check("cpu_run_low", 32'(cpu_run), 32'd0);
      check("busy_in_load", 32'(busy), 32'd1);
      check("addr_cleared", 32'(ram_addr), 32'd0);
      check("overrun_cleared", 32'(overrun), 32'd0);
    end else begin
      m_loading = 1'b0;
      wait_run();
    end
  endtask

  task automatic check_state();
    check("overrun", 32'(overrun), 32'(m_overrun));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(m_csum));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_data"}, 32'(ram_data), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
  endtask

  initial begin
    int k;
    load_mode = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_run", 32'(cpu_run), 32'd0);
    model_enter_load();
    repeat (7) @(negedge clk);
    check("first_load_busy", 32'(busy), 32'd1);

    // full load 0x10..0x1F, then one byte too many
    for (int i = 0; i < RAM_BYTES; i++) send_byte(8'(8'h10 + i), 1'b0);
    check_state();
    check("full_busy", 32'(busy), 32'd0);
    check("full_addr_wrap", 32'(ram_addr), 32'd0);
    send_byte(8'hA5, 1'b0);
    check_state();

    set_mode(1'b0);
    send_byte(8'h5A, 1'b0);
    check_state();

    // reload clears state; small checksum case
    set_mode(1'b1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    check_state();
`ifdef PROG_LOADER_CHECKSUM_EN
    check("checksum_0x11", 32'(checksum), 32'h11);
`endif
    check("partial_addr", 32'(ram_addr), 32'd3);

    // mode drop coincident with the fourth strobe
    set_mode(1'b0);
    set_mode(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    wait_run();
    check_state();

    // random-length loads, some overrunning
    for (int r = 0; r < 5; r++) begin
      set_mode(1'b1);
      k = int'($urandom_range(5, 19));
      for (int i = 0; i < k; i++) send_byte(8'($urandom), 1'b0);
      check("rand_busy", 32'(busy), 32'(k < RAM_BYTES));
      check_state();
      set_mode(1'b0);
    end

    // reset asserted while the write pulse is high
    set_mode(1'b1);
    @(negedge clk);
    load_data   = 8'hC3;
    load_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("midwrite_we", 32'(ram_we), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    load_strobe = 1'b0;
    load_mode   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("held");
    check("queue_final", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
